a2d_spi_slv: RTL and testbench

A2D_SPI_SLV -- requirements
Module: a2d_spi_slv

---
 rtl/a2d_spi_slv.sv | 123 ++++++++++++
 tb/tb_a2d_spi_slv.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_spi_slv.sv
// SPI slave front end for an 8-channel 12-bit ADC: 16-bit command frames in, pipelined sample out.
// Latency: 2-flop sync + edge detect; MISO moves 3 clk after a sampled SCLK fall, pulses 1 clk after SS_n rise is seen.
// Backpressure: none; the SPI master owns timing, and frames of the wrong length end with frm_err.
module a2d_spi_slv (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [95:0] ch_val,
  output logic        cmd_vld,
  output logic [2:0]  cmd_chnl,
  output logic        frm_err,
  output logic [7:0]  cnv_cnt
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state;
  logic        ss_s1, ss_s2, ss_h;
  logic        sclk_s1, sclk_s2, sclk_h;
  logic        mosi_s1, mosi_s2;
  logic [4:0]  bit_cnt;
  logic [15:0] tx_shft;
  logic [14:0] rx_shft;
  logic [2:0]  sel;
  logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [11:0] ch_arr [8];

  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : g_ch
      assign ch_arr[g] = ch_val[12*g +: 12];
    end
  endgenerate

  // SS_n flops start low so a frame already in progress at reset release never looks like a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_s1   <= 1'b0;
      ss_s2   <= 1'b0;
      ss_h    <= 1'b0;
      sclk_s1 <= 1'b1;
      sclk_s2 <= 1'b1;
      sclk_h  <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      ss_s1   <= SS_n;
      ss_s2   <= ss_s1;
      ss_h    <= ss_s2;
      sclk_s1 <= SCLK;
      sclk_s2 <= sclk_s1;
      sclk_h  <= sclk_s2;
      mosi_s1 <= MOSI;
      mosi_s2 <= mosi_s1;
    end
  end

  assign ss_fall   = ss_h & ~ss_s2;
  assign ss_rise   = ~ss_h & ss_s2;
  assign sclk_rise = ~sclk_h & sclk_s2;
  assign sclk_fall = sclk_h & ~sclk_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= 5'd0;
      tx_shft  <= 16'h0000;
      rx_shft  <= 15'h0000;
      sel      <= 3'd0;
      MISO     <= 1'b0;
      cmd_vld  <= 1'b0;
      frm_err  <= 1'b0;
      cmd_chnl <= 3'd0;
      cnv_cnt  <= 8'd0;
    end else begin
      cmd_vld <= 1'b0;
      frm_err <= 1'b0;
      case (state)
        IDLE: begin
          MISO <= 1'b0;
          if (ss_fall) begin
            state   <= SHIFT;
            tx_shft <= {4'h0, ~ch_arr[sel]};
            bit_cnt <= 5'd0;
            rx_shft <= 15'h0000;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state <= IDLE;
            MISO  <= 1'b0;
            if (bit_cnt == 5'd16) begin
              cmd_vld  <= 1'b1;
              cmd_chnl <= rx_shft[13:11];
              sel      <= rx_shft[13:11];
              cnv_cnt  <= cnv_cnt + 8'd1;
            end else begin
              frm_err  <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              rx_shft <= {rx_shft[13:0], mosi_s2};
              if (bit_cnt != 5'd17)
                bit_cnt <= bit_cnt + 5'd1;
            end
            // A fall before the first rise is an idle-high master's leading edge, not a bit boundary.
            if (sclk_fall && bit_cnt != 5'd0) begin
              tx_shft <= {tx_shft[14:0], 1'b0};
              MISO    <= tx_shft[14];
            end else begin
              MISO    <= tx_shft[15];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_spi_slv.sv
// Randomized SPI master with a frame-level reference model; a monitor scores pulses and MISO words from queues.
module tb_a2d_spi_slv;

  logic        clk = 1'b0;
  logic        rst;
  logic        SS_n, SCLK, MOSI;
  logic        MISO;
  logic [95:0] ch_val;
  logic        cmd_vld, frm_err;
  logic [2:0]  cmd_chnl;
  logic [7:0]  cnv_cnt;
  logic [11:0] ch [8];

  always #5 clk = ~clk;

  always_comb begin
    ch_val = '0;
    for (int i = 0; i < 8; i++) ch_val[12*i +: 12] = ch[i];
  end

  a2d_spi_slv dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .ch_val(ch_val), .cmd_vld(cmd_vld), .cmd_chnl(cmd_chnl), .frm_err(frm_err), .cnv_cnt(cnv_cnt)
  );

  typedef struct packed {
    logic       err;
    logic [2:0] chnl;
    logic [7:0] cnt;
  } ev_t;

  int          checks = 0;
  int          errors = 0;
  ev_t         ev_q[$];
  logic [15:0] mexp_q[$];
  logic [15:0] mobs_q[$];
  logic [2:0]  m_sel, m_chnl;
  logic [7:0]  m_cnt;
  ev_t         mon_e;
  logic [15:0] mon_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    m_sel = 3'd0; m_chnl = 3'd0; m_cnt = 8'd0;
    cyc(2);
  endtask

  // One SPI frame with nr rising edges; the response expected is the sample picked by the previous good command.
  task automatic frame(input logic [15:0] cmd, input int nr, input bit idle_high, input bit chg);
    logic [15:0] cap;
    ev_t         e;
    cap  = 16'h0;
    SCLK = idle_high;
    cyc(6);
    SS_n = 1'b0;
    if (nr == 16) begin
      mexp_q.push_back({4'h0, ~ch[m_sel]});
      m_sel  = cmd[13:11];
      m_chnl = cmd[13:11];
      m_cnt  = m_cnt + 8'd1;
      e = '{err: 1'b0, chnl: m_chnl, cnt: m_cnt};
    end else begin
      e = '{err: 1'b1, chnl: m_chnl, cnt: m_cnt};
    end
    ev_q.push_back(e);
    cyc(6);
    if (idle_high) begin
      SCLK = 1'b0;
      cyc(5);
    end
    for (int i = 0; i < nr; i++) begin
      MOSI = (i < 16) ? cmd[15-i] : 1'($urandom);
      cyc(5);
      if (i < 16) cap = {cap[14:0], MISO};
      if (chg && i == 4) ch[3] = 12'h111;
      SCLK = 1'b1;
      cyc(5);
      if (i < nr-1 || !idle_high) SCLK = 1'b0;
    end
    cyc(5);
    SS_n = 1'b1;
    if (nr == 16) mobs_q.push_back(cap);
    cyc(8);
  endtask

  // Frame interrupted by reset after 8 bits; the remainder must be ignored.
  task automatic frame_rst(input logic [15:0] cmd);
    SCLK = 1'b0;
    cyc(6);
    SS_n = 1'b0;
    cyc(6);
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        m_sel = 3'd0; m_chnl = 3'd0; m_cnt = 8'd0;
      end
      MOSI = cmd[15-i];
      cyc(5);
      if (i >= 8) check("rst_miso_low", MISO, 0);
      SCLK = 1'b1;
      cyc(5);
      SCLK = 1'b0;
    end
    cyc(5);
    SS_n = 1'b1;
    cyc(8);
    check("rst_cmd_chnl", cmd_chnl, m_chnl);
    check("rst_cnv_cnt", cnv_cnt, m_cnt);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_vld || frm_err) begin
        if (ev_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got cmd_vld=%0b frm_err=%0b expected none", cmd_vld, frm_err);
        end else begin
          mon_e = ev_q.pop_front();
          check("pulse_kind", {cmd_vld, frm_err}, mon_e.err ? 2'b01 : 2'b10);
          check("cmd_chnl", cmd_chnl, mon_e.chnl);
          check("cnv_cnt", cnv_cnt, mon_e.cnt);
        end
      end
      if (mobs_q.size() != 0) begin
        mon_w = mobs_q.pop_front();
        if (mexp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL miso_word: got 0x%0h expected no frame", mon_w);
        end else begin
          check("miso_word", mon_w, mexp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish before time limit");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    m_sel = 3'd0; m_chnl = 3'd0; m_cnt = 8'd0;
    for (int k = 0; k < 8; k++) ch[k] = 12'($urandom);
    ch[0] = 12'h000;
    ch[3] = 12'h5A3;
    cyc(4);
    check("reset_miso", MISO, 0);
    check("reset_cmd_vld", cmd_vld, 0);
    check("reset_frm_err", frm_err, 0);
    check("reset_cmd_chnl", cmd_chnl, 0);
    check("reset_cnv_cnt", cnv_cnt, 0);
    rst = 1'b0;
    cyc(2);

    // Idle-low master, then the same pair with an idle-high master after reset.
    frame(16'h1800, 16, 1'b0, 1'b0);
    check("first_cmd_chnl", cmd_chnl, 3);
    check("first_cnv_cnt", cnv_cnt, 1);
    frame(16'h0000, 16, 1'b0, 1'b0);
    do_reset;
    frame(16'h1800, 16, 1'b1, 1'b0);
    frame(16'h0000, 16, 1'b1, 1'b0);

    // Short and long frames leave the selection and count alone.
    frame(16'h2800, 15, 1'b0, 1'b0);
    frame(16'h3000, 17, 1'b1, 1'b0);
    frame(16'h0800, 16, 1'b0, 1'b0);

    // Sample changes mid-frame must not reach MISO.
    frame(16'h1800, 16, 1'b0, 1'b0);
    frame(16'h0000, 16, 1'b0, 1'b1);

    for (int n = 0; n < 20; n++) begin
      int len;
      len = ($urandom_range(4) == 0) ? int'($urandom_range(18, 14)) : 16;
      if ($urandom_range(3) == 0) ch[$urandom_range(7)] = 12'($urandom);
      frame(16'($urandom), len, 1'($urandom), 1'b0);
    end

    frame_rst(16'h1800);
    frame(16'h0000, 16, 1'b0, 1'b0);

    do_reset;
    for (int n = 0; n < 256; n++) begin
      if ($urandom_range(7) == 0) ch[$urandom_range(7)] = 12'($urandom);
      frame(16'($urandom), 16, 1'($urandom), 1'b0);
    end
    check("cnv_wrap", cnv_cnt, 0);

    cyc(10);
    check("events_drained", ev_q.size(), 0);
    check("miso_drained", mexp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
